// File: rtl/data_mem_responder.sv
// Load/store memory responder: latches one request, waits WAIT_CYCLES, accesses a word RAM,
// then holds the response until accepted. Optional error reporting is enabled by `DMEM_ERR_EN.
module data_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_be,
    input  logic              i_wen,
    input  logic              i_ren,
    output logic              o_rsp_valid,
`ifdef DMEM_ERR_EN
    output logic              o_rsp_err,
`endif
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_rdata
);

    localparam int unsigned IdxW    = $clog2(DEPTH);
    localparam logic [3:0]  CntLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic              oor_q, oor_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       mem_q [DEPTH];

    logic              accept;
    logic              exec;
    logic              rsp_done;
    logic [IdxW-1:0]   req_idx;
    logic              req_oor;
    logic              req_wr;
    logic              req_rd;

    logic              from_req;
    logic [IdxW-1:0]   acc_idx;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic              acc_wr;
    logic              acc_rd;
    logic              acc_oor;
    logic              acc_err;
    logic [31:0]       acc_old;
    logic [31:0]       acc_merged;
    logic              mem_we;

    assign o_req_ready = (state_q == StIdle) && i_rst_n;
    assign accept      = i_req_valid && o_req_ready;
    assign o_rsp_valid = (state_q == StResp);
    assign o_rsp_rdata = rdata_q;

    // Write wins over read; neither set is a no-op that still responds.
    assign req_idx = i_addr[IdxW+1:2];
    assign req_oor = |(i_addr >> (IdxW + 2));
    assign req_wr  = i_wen;
    assign req_rd  = i_ren && !i_wen;

    // With zero wait states the access happens on the accept edge, straight from the inputs.
    assign from_req  = (state_q == StIdle);
    assign acc_idx   = from_req ? req_idx : idx_q;
    assign acc_wdata = from_req ? i_wdata : wdata_q;
    assign acc_be    = from_req ? i_be    : be_q;
    assign acc_wr    = from_req ? req_wr  : wr_q;
    assign acc_rd    = from_req ? req_rd  : rd_q;
    assign acc_oor   = from_req ? req_oor : oor_q;
    assign acc_old   = mem_q[acc_idx];

`ifdef DMEM_ERR_EN
    function automatic logic be_noncontig(input logic [3:0] be);
        logic r;
        unique case (be)
            4'b0101, 4'b1001, 4'b1010, 4'b1011, 4'b1101: r = 1'b1;
            default:                                     r = 1'b0;
        endcase
        return r;
    endfunction

    assign acc_err = acc_oor || (acc_wr && be_noncontig(acc_be));
`else
    logic unused_oor;
    assign unused_oor = acc_oor;
    assign acc_err    = 1'b0;
`endif

    always_comb begin
        acc_merged = acc_old;
        for (int n = 0; n < 4; n++) begin
            if (acc_be[n]) begin
                acc_merged[8*n +: 8] = acc_wdata[8*n +: 8];
            end
        end
    end

    // A write still in WAIT when reset arrives must not land.
    assign mem_we = exec && acc_wr && !acc_err && i_rst_n;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        oor_d    = oor_q;
        rdata_d  = rdata_q;
        exec     = 1'b0;
        rsp_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    idx_d   = req_idx;
                    wdata_d = i_wdata;
                    be_d    = i_be;
                    wr_d    = req_wr;
                    rd_d    = req_rd;
                    oor_d   = req_oor;
                    if (WAIT_CYCLES == 0) begin
                        exec    = 1'b1;
                        state_d = StResp;
                    end else begin
                        cnt_d   = CntLoad;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    exec    = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (i_rsp_ready) begin
                    rsp_done = 1'b1;
                    rdata_d  = 32'd0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (exec) begin
            rdata_d = (acc_rd && !acc_err) ? acc_old : 32'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            oor_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[acc_idx] <= acc_merged;
        end
    end

`ifdef DMEM_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (exec) begin
            err_d = acc_err;
        end else if (rsp_done) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_rsp_err = err_q;
`else
    logic unused_done;
    assign unused_done = rsp_done;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table plus stall and mid-operation reset cases.
module tb_data_mem_responder;

    localparam int unsigned Wait = 1;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wen;
    logic        ren;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
`ifdef DMEM_ERR_EN
    logic        rsp_err;
`endif

    int checks   = 0;
    int failures = 0;

    data_mem_responder #(
        .DEPTH      (1024),
        .ADDR_W     (32),
        .WAIT_CYCLES(Wait)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .i_be       (be),
        .i_wen      (wen),
        .i_ren      (ren),
        .o_rsp_valid(rsp_valid),
`ifdef DMEM_ERR_EN
        .o_rsp_err  (rsp_err),
`endif
        .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        wen;
        logic        ren;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] w, input logic [3:0] b,
                       input logic we, input logic re, input logic [31:0] er,
                       input logic ee);
        vec_t v;
        v.addr = a; v.wdata = w; v.be = b; v.wen = we; v.ren = re;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    // Drives one request, returns edges from accept to response, response data/err.
    // Leaves time at #1 after the response handshake edge when rsp_ready is high.
    task automatic xact(input vec_t v, output int lat, output logic [31:0] rd,
                        output logic er);
        @(negedge clk);
        req_valid = 1'b1; addr = v.addr; wdata = v.wdata; be = v.be;
        wen = v.wen; ren = v.ren;
        @(posedge clk); #1;
        req_valid = 1'b0; wen = 1'b0; ren = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
`ifdef DMEM_ERR_EN
        er = rsp_err;
`else
        er = 1'b0;
`endif
        if (rsp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          lat;
        logic [31:0] rd;
        logic        er;
        chk({tag, "_ready_before"}, 32'(req_ready), 32'd1);
        xact(v, lat, rd, er);
        chk({tag, "_latency"}, 32'(lat), 32'(Wait));
        chk({tag, "_rdata"}, rd, v.exp_rdata);
`ifdef DMEM_ERR_EN
        chk({tag, "_err"}, 32'(er), 32'(v.exp_err));
`endif
        chk({tag, "_valid_after"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rdata_after"}, rsp_rdata, 32'd0);
    endtask

    initial begin
        vec_t        v;
        int          stray;
        int          lat;

        rst_n = 1'b0; req_valid = 1'b0; addr = '0; wdata = '0; be = '0;
        wen = 1'b0; ren = 1'b0; rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", 32'(req_ready), 32'd1);

        add(32'h10, 32'hDEADBEEF, 4'b1111, 1, 0, 32'h0,        0);
        add(32'h10, 32'h0,        4'b0000, 0, 1, 32'hDEADBEEF, 0);
        add(32'h10, 32'h00AA0000, 4'b0100, 1, 0, 32'h0,        0);
        add(32'h10, 32'h0,        4'b0000, 0, 1, 32'hDEAABEEF, 0);
        add(32'h10, 32'hFFFFFFFF, 4'b0000, 1, 0, 32'h0,        0);
        add(32'h10, 32'h0,        4'b0000, 0, 1, 32'hDEAABEEF, 0);
        add(32'h20, 32'h12345678, 4'b1111, 1, 1, 32'h0,        0);
        add(32'h20, 32'h0,        4'b0000, 0, 1, 32'h12345678, 0);
        add(32'h20, 32'hFFFFFFFF, 4'b1111, 0, 0, 32'h0,        0);
        add(32'h30, 32'hCAFEF00D, 4'b1111, 1, 0, 32'h0,        0);
        add(32'h33, 32'h0,        4'b0000, 0, 1, 32'hCAFEF00D, 0);
        add(32'h04, 32'hAABBCCDD, 4'b1111, 1, 0, 32'h0,        0);
        add(32'h06, 32'h55660000, 4'b1100, 1, 0, 32'h0,        0);
        add(32'h04, 32'h0,        4'b0000, 0, 1, 32'h5566CCDD, 0);
        add(32'h00, 32'h01010101, 4'b1111, 1, 0, 32'h0,        0);
`ifdef DMEM_ERR_EN
        add(32'h1000, 32'h0BADF00D, 4'b1111, 1, 0, 32'h0,        1);
        add(32'h0000, 32'h0,        4'b0000, 0, 1, 32'h01010101, 0);
        add(32'h0000, 32'hFFFFFFFF, 4'b0101, 1, 0, 32'h0,        1);
        add(32'h0000, 32'h0,        4'b0000, 0, 1, 32'h01010101, 0);
        add(32'h1000, 32'h0,        4'b0000, 0, 1, 32'h0,        1);
`else
        add(32'h1000, 32'h0BADF00D, 4'b1111, 1, 0, 32'h0,        0);
        add(32'h0000, 32'h0,        4'b0000, 0, 1, 32'h0BADF00D, 0);
        add(32'h0000, 32'hFFFFFFFF, 4'b0101, 1, 0, 32'h0,        0);
        add(32'h0000, 32'h0,        4'b0000, 0, 1, 32'h0BFFF0FF, 0);
        add(32'h1000, 32'h0,        4'b0000, 0, 1, 32'h0BFFF0FF, 0);
`endif

        foreach (vecs[i]) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Response stall: read held for five cycles with rsp_ready low.
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; addr = 32'h10; be = 4'b0000; wen = 1'b0; ren = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; ren = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("stall_latency", 32'(lat), 32'(Wait));
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d_rdata", k), rsp_rdata, 32'hDEAABEEF);
            chk($sformatf("stall%0d_ready", k), 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_valid", 32'(rsp_valid), 32'd0);
        chk("stall_release_ready", 32'(req_ready), 32'd1);

        // Reset while a write to 0x30 is still waiting: write must be dropped.
        @(negedge clk);
        req_valid = 1'b1; addr = 32'h30; wdata = 32'h99999999; be = 4'b1111;
        wen = 1'b1; ren = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; wen = 1'b0;
        chk("rst_mid_in_wait", 32'(rsp_valid), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ready_low", 32'(req_ready), 32'd0);
        chk("rst_mid_valid_low", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) stray++;
        end
        chk("rst_mid_no_stray_valid", 32'(stray), 32'd0);
        v.addr = 32'h30; v.wdata = 32'h0; v.be = 4'b0000; v.wen = 1'b0; v.ren = 1'b1;
        v.exp_rdata = 32'hCAFEF00D; v.exp_err = 1'b0;
        run_vec(v, "rst_mid_read_back");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
